// File: rtl/access_parking_ctrl_pkg.sv
// Shared types and width helpers for the parking access controller.
package access_parking_ctrl_pkg;

  // Controller states; encoding is fixed so external monitors can decode it.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StEsperaPin = 2'd1,
    StAbierta   = 2'd2,
    StBloqueo   = 2'd3
  } estado_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned ancho_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/access_parking_ctrl_if.sv
// Sensor/keypad inputs and gate/alarm/occupancy outputs of the parking controller.
interface access_parking_ctrl_if #(
  parameter int unsigned PIN_WIDTH = 16,
  parameter int unsigned CAPACIDAD = 8
);
  localparam int unsigned OcupW = $clog2(CAPACIDAD + 1);

  logic                 sensor_llegada_vehiculo;
  logic                 sensor_ingreso_vehiculo;
  logic                 sensor_salida_vehiculo;
  logic [PIN_WIDTH-1:0] clave_ingresada;
  logic                 clave_valida;
  logic                 senal_compuerta;
  logic                 senal_alarma_pin;
  logic                 senal_alarma_bloqueo;
  logic [OcupW-1:0]     ocupacion;
  logic                 senal_lleno;

  // Environment side: sensors and keypad.
  modport master (
    output sensor_llegada_vehiculo, sensor_ingreso_vehiculo, sensor_salida_vehiculo,
    output clave_ingresada, clave_valida,
    input  senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, ocupacion, senal_lleno
  );

  // Controller side.
  modport slave (
    input  sensor_llegada_vehiculo, sensor_ingreso_vehiculo, sensor_salida_vehiculo,
    input  clave_ingresada, clave_valida,
    output senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, ocupacion, senal_lleno
  );

endinterface

// File: rtl/access_parking_ctrl_contador_ocupacion.sv
// Lot occupancy: exit-lane rising-edge detector plus saturating up/down counter.
module access_parking_ctrl_contador_ocupacion #(
  parameter int unsigned Capacidad = 8,
  parameter int unsigned OcupW     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             salida_i,
  input  logic             entrada_i,
  output logic [OcupW-1:0] ocupacion_o,
  output logic             lleno_o
);

  localparam logic [OcupW-1:0] Cap = OcupW'(Capacidad);

  logic             salida_q;
  logic [OcupW-1:0] ocup_q, ocup_d;
  logic             lleno_q;
  logic             salida_flanco;

  assign salida_flanco = salida_i && !salida_q;

  // Next count; a simultaneous entry and departure cancel out.
  always_comb begin
    ocup_d = ocup_q;
    if (entrada_i && !salida_flanco) begin
      if (ocup_q != Cap) ocup_d = ocup_q + 1'b1;
    end else if (salida_flanco && !entrada_i) begin
      if (ocup_q != '0) ocup_d = ocup_q - 1'b1;
    end
  end

  // Edge-detect register, count and full flag update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      salida_q <= 1'b0;
      ocup_q   <= '0;
      lleno_q  <= 1'b0;
    end else begin
      salida_q <= salida_i;
      ocup_q   <= ocup_d;
      lleno_q  <= (ocup_d == Cap);
    end
  end

  assign ocupacion_o = ocup_q;
  assign lleno_o     = lleno_q;

endmodule

// File: rtl/access_parking_ctrl.sv
// Parking gate controller: arrival, PIN entry with retry limit, open timeout,
// tailgate/forced-entry lockout and occupancy tracking.
module access_parking_ctrl
  import access_parking_ctrl_pkg::*;
#(
  parameter int unsigned          PIN_WIDTH      = 16,
  parameter logic [PIN_WIDTH-1:0] CLAVE_CORRECTA = 16'h3257,
  parameter int unsigned          MAX_INTENTOS   = 3,
  parameter int unsigned          TIMEOUT_CICLOS = 64,
  parameter int unsigned          CAPACIDAD      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  access_parking_ctrl_if.slave bus
);

  localparam int unsigned IntW   = ancho_min1(MAX_INTENTOS + 1);
  localparam int unsigned TimerW = ancho_min1(TIMEOUT_CICLOS);
  localparam int unsigned OcupW  = $clog2(CAPACIDAD + 1);

  localparam logic [IntW-1:0]   IntMax   = IntW'(MAX_INTENTOS);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CICLOS - 1);

  estado_e           estado_q;
  logic [IntW-1:0]   intentos_q;
  logic [TimerW-1:0] timer_q;
  logic              compuerta_q;
  logic              alarma_pin_q;
  logic              alarma_bloqueo_q;

  logic llegada, ingreso, clave_ok, entrada, lleno;

  assign llegada  = bus.sensor_llegada_vehiculo;
  assign ingreso  = bus.sensor_ingreso_vehiculo;
  assign clave_ok = bus.clave_valida && (bus.clave_ingresada == CLAVE_CORRECTA);
  // A clean single-car entry is the only event that bumps occupancy.
  assign entrada  = (estado_q == StAbierta) && ingreso && !llegada;

  // Controller FSM with registered gate and alarm outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q         <= StIdle;
      intentos_q       <= '0;
      timer_q          <= '0;
      compuerta_q      <= 1'b0;
      alarma_pin_q     <= 1'b0;
      alarma_bloqueo_q <= 1'b0;
    end else begin
      compuerta_q <= 1'b0;
      unique case (estado_q)
        StIdle: begin
          if (ingreso) begin
            estado_q         <= StBloqueo;
            alarma_bloqueo_q <= 1'b1;
          end else if (llegada && !lleno) begin
            estado_q <= StEsperaPin;
          end
        end
        StEsperaPin: begin
          if (ingreso) begin
            estado_q         <= StBloqueo;
            alarma_bloqueo_q <= 1'b1;
          end else if (bus.clave_valida) begin
            if (clave_ok) begin
              estado_q     <= StAbierta;
              intentos_q   <= '0;
              alarma_pin_q <= 1'b0;
              timer_q      <= '0;
              compuerta_q  <= 1'b1;
            end else begin
              if (intentos_q != IntMax) intentos_q <= intentos_q + 1'b1;
              // This strobe brings the count to the limit (or it is already there).
              if (intentos_q >= IntMax - 1'b1) alarma_pin_q <= 1'b1;
            end
          end else if (!llegada) begin
            estado_q     <= StIdle;
            intentos_q   <= '0;
            alarma_pin_q <= 1'b0;
          end
        end
        StAbierta: begin
          if (ingreso && !llegada) begin
            estado_q <= StIdle;
          end else if (ingreso) begin
            estado_q         <= StBloqueo;
            alarma_bloqueo_q <= 1'b1;
          end else if (timer_q == TimerMax) begin
            estado_q   <= StEsperaPin;
            intentos_q <= '0;
          end else begin
            timer_q     <= timer_q + 1'b1;
            compuerta_q <= 1'b1;
          end
        end
        StBloqueo: begin
          if (clave_ok) begin
            estado_q         <= StIdle;
            alarma_bloqueo_q <= 1'b0;
            alarma_pin_q     <= 1'b0;
          end
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

  access_parking_ctrl_contador_ocupacion #(
    .Capacidad (CAPACIDAD),
    .OcupW     (OcupW)
  ) u_contador_ocupacion (
    .clock       (clock),
    .reset       (reset),
    .salida_i    (bus.sensor_salida_vehiculo),
    .entrada_i   (entrada),
    .ocupacion_o (bus.ocupacion),
    .lleno_o     (lleno)
  );

  assign bus.senal_compuerta      = compuerta_q;
  assign bus.senal_alarma_pin     = alarma_pin_q;
  assign bus.senal_alarma_bloqueo = alarma_bloqueo_q;
  assign bus.senal_lleno          = lleno;

endmodule

// File: tb/tb_access_parking_ctrl.sv
// Bench for access_parking_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model. Two instances: capacity 8 (A) and capacity 2 (B).
module tb_access_parking_ctrl;

  localparam logic [15:0] Clave   = 16'h3257;
  localparam int          MaxInt  = 3;
  localparam int          Timeout = 64;

  // Model modes, named by what the driver experiences.
  localparam int ModeFree   = 0;
  localparam int ModeAskPin = 1;
  localparam int ModeGateUp = 2;
  localparam int ModeAlarm  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        llegada = 1'b0, ingreso = 1'b0, salida = 1'b0, valida = 1'b0;
  logic [15:0] clave = 16'h0;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode[2], m_tries[2], m_open[2], m_occ[2], cap[2];
  bit m_prev[2], m_apin[2], m_abloq[2];

  access_parking_ctrl_if #(.PIN_WIDTH(16), .CAPACIDAD(8)) bus_a ();
  access_parking_ctrl_if #(.PIN_WIDTH(16), .CAPACIDAD(2)) bus_b ();

  assign bus_a.sensor_llegada_vehiculo = llegada;
  assign bus_a.sensor_ingreso_vehiculo = ingreso;
  assign bus_a.sensor_salida_vehiculo  = salida;
  assign bus_a.clave_ingresada         = clave;
  assign bus_a.clave_valida            = valida;
  assign bus_b.sensor_llegada_vehiculo = llegada;
  assign bus_b.sensor_ingreso_vehiculo = ingreso;
  assign bus_b.sensor_salida_vehiculo  = salida;
  assign bus_b.clave_ingresada         = clave;
  assign bus_b.clave_valida            = valida;

  access_parking_ctrl #(
    .PIN_WIDTH(16), .CLAVE_CORRECTA(16'h3257), .MAX_INTENTOS(3), .TIMEOUT_CICLOS(64),
    .CAPACIDAD(8)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  access_parking_ctrl #(
    .PIN_WIDTH(16), .CLAVE_CORRECTA(16'h3257), .MAX_INTENTOS(3), .TIMEOUT_CICLOS(64),
    .CAPACIDAD(2)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one rising edge; the model sees the same input values the DUTs sample.
  task automatic tick();
    int  occ, entered, exit_edge;
    bit  pin_ok;
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] = ModeFree; m_tries[k] = 0; m_open[k] = 0; m_occ[k] = 0;
        m_prev[k] = 0; m_apin[k] = 0; m_abloq[k] = 0;
      end else begin
        exit_edge = (salida && !m_prev[k]) ? 1 : 0;
        m_prev[k] = salida;
        entered = 0;
        pin_ok = valida && (clave == Clave);
        case (m_mode[k])
          ModeFree: begin
            if (ingreso) begin m_mode[k] = ModeAlarm; m_abloq[k] = 1; end
            else if (llegada && m_occ[k] < cap[k]) m_mode[k] = ModeAskPin;
          end
          ModeAskPin: begin
            if (ingreso) begin m_mode[k] = ModeAlarm; m_abloq[k] = 1; end
            else if (valida) begin
              if (pin_ok) begin
                m_mode[k] = ModeGateUp; m_tries[k] = 0; m_apin[k] = 0; m_open[k] = 1;
              end else begin
                m_tries[k] = (m_tries[k] + 1 > MaxInt) ? MaxInt : m_tries[k] + 1;
                if (m_tries[k] >= MaxInt) m_apin[k] = 1;
              end
            end else if (!llegada) begin
              m_mode[k] = ModeFree; m_tries[k] = 0; m_apin[k] = 0;
            end
          end
          ModeGateUp: begin
            if (ingreso && !llegada) begin m_mode[k] = ModeFree; entered = 1; end
            else if (ingreso) begin m_mode[k] = ModeAlarm; m_abloq[k] = 1; end
            else if (m_open[k] == Timeout) begin m_mode[k] = ModeAskPin; m_tries[k] = 0; end
            else m_open[k]++;
          end
          default: begin
            if (pin_ok) begin m_mode[k] = ModeFree; m_abloq[k] = 0; m_apin[k] = 0; end
          end
        endcase
        occ = m_occ[k] + entered - exit_edge;
        if (occ < 0) occ = 0;
        if (occ > cap[k]) occ = cap[k];
        m_occ[k] = occ;
      end
    end
    #1;
  endtask

  task automatic pin(input logic [15:0] v);
    clave = v; valida = 1'b1;
    tick();
    valida = 1'b0; clave = 16'h0;
  endtask

  task automatic full_entry();
    llegada = 1'b1; tick();
    pin(Clave);
    ingreso = 1'b1; llegada = 1'b0; tick();
    ingreso = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++;
    if ({bus_a.senal_compuerta, bus_a.senal_alarma_pin, bus_a.senal_alarma_bloqueo,
         bus_a.senal_lleno} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got gate/apin/abloq/lleno=%b%b%b%b want 0000",
               bus_a.senal_compuerta, bus_a.senal_alarma_pin, bus_a.senal_alarma_bloqueo,
               bus_a.senal_lleno);
    end
    n_cmp++;
    if (bus_a.ocupacion !== 4'd0) begin
      n_err++; $display("FAIL reset_ocupacion: got %0d want 0", bus_a.ocupacion);
    end
  endtask

  task automatic test_normal_entry();
    llegada = 1'b1; tick();
    pin(Clave);
    n_cmp++;
    if (bus_a.senal_compuerta !== 1'b1) begin
      n_err++; $display("FAIL entry_gate_open: got %b want 1", bus_a.senal_compuerta);
    end
    ingreso = 1'b1; llegada = 1'b0; tick(); ingreso = 1'b0;
    n_cmp++;
    if (bus_a.senal_compuerta !== 1'b0 || bus_a.ocupacion !== 4'd1) begin
      n_err++;
      $display("FAIL entry_done: got gate=%b ocup=%0d want gate=0 ocup=1",
               bus_a.senal_compuerta, bus_a.ocupacion);
    end
  endtask

  task automatic test_wrong_pin();
    llegada = 1'b1; tick();
    pin(16'h0000);
    n_cmp++;
    if (bus_a.senal_alarma_pin !== 1'b0) begin
      n_err++; $display("FAIL wrong_pin_first: got apin=%b want 0", bus_a.senal_alarma_pin);
    end
    pin(16'h0000);
    pin(16'h0000);
    n_cmp++;
    if (bus_a.senal_alarma_pin !== 1'b1 || bus_a.senal_compuerta !== 1'b0) begin
      n_err++;
      $display("FAIL wrong_pin_third: got apin=%b gate=%b want apin=1 gate=0",
               bus_a.senal_alarma_pin, bus_a.senal_compuerta);
    end
    pin(Clave);
    n_cmp++;
    if (bus_a.senal_alarma_pin !== 1'b0 || bus_a.senal_compuerta !== 1'b1) begin
      n_err++;
      $display("FAIL wrong_pin_recover: got apin=%b gate=%b want apin=0 gate=1",
               bus_a.senal_alarma_pin, bus_a.senal_compuerta);
    end
    ingreso = 1'b1; llegada = 1'b0; tick(); ingreso = 1'b0;
    n_cmp++;
    if (bus_a.ocupacion !== 4'd2) begin
      n_err++; $display("FAIL wrong_pin_entry: got ocup=%0d want 2", bus_a.ocupacion);
    end
  endtask

  task automatic test_tailgate();
    llegada = 1'b1; tick();
    pin(Clave);
    ingreso = 1'b1; tick(); ingreso = 1'b0; llegada = 1'b0;
    n_cmp++;
    if (bus_a.senal_alarma_bloqueo !== 1'b1 || bus_a.senal_compuerta !== 1'b0 ||
        bus_a.ocupacion !== 4'd2) begin
      n_err++;
      $display("FAIL tailgate_lock: got abloq=%b gate=%b ocup=%0d want 1 0 2",
               bus_a.senal_alarma_bloqueo, bus_a.senal_compuerta, bus_a.ocupacion);
    end
    pin(16'h1111);
    n_cmp++;
    if (bus_a.senal_alarma_bloqueo !== 1'b1 || bus_a.senal_alarma_pin !== 1'b0) begin
      n_err++;
      $display("FAIL tailgate_wrong_pin: got abloq=%b apin=%b want 1 0",
               bus_a.senal_alarma_bloqueo, bus_a.senal_alarma_pin);
    end
    pin(Clave);
    n_cmp++;
    if (bus_a.senal_alarma_bloqueo !== 1'b0 || bus_a.senal_compuerta !== 1'b0) begin
      n_err++;
      $display("FAIL tailgate_unlock: got abloq=%b gate=%b want 0 0",
               bus_a.senal_alarma_bloqueo, bus_a.senal_compuerta);
    end
    // Back in IDLE a PIN alone must not open the gate.
    pin(Clave);
    n_cmp++;
    if (bus_a.senal_compuerta !== 1'b0) begin
      n_err++; $display("FAIL tailgate_idle: got gate=%b want 0", bus_a.senal_compuerta);
    end
    full_entry();
    n_cmp++;
    if (bus_a.ocupacion !== 4'd3) begin
      n_err++; $display("FAIL tailgate_after: got ocup=%0d want 3", bus_a.ocupacion);
    end
  endtask

  task automatic test_timeout();
    int n;
    llegada = 1'b1; tick();
    pin(Clave);
    n = (bus_a.senal_compuerta === 1'b1) ? 1 : 0;
    for (int i = 0; i < 200 && bus_a.senal_compuerta === 1'b1; i++) begin
      tick();
      if (bus_a.senal_compuerta === 1'b1) n++;
    end
    n_cmp++;
    if (n != Timeout || bus_a.senal_compuerta !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d open cycles (gate=%b) want %0d then 0", n,
               bus_a.senal_compuerta, Timeout);
    end
    // ESPERA_PIN: a correct PIN reopens without a new arrival edge.
    pin(Clave);
    n_cmp++;
    if (bus_a.senal_compuerta !== 1'b1 || bus_a.senal_alarma_pin !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_reenter: got gate=%b apin=%b want 1 0",
               bus_a.senal_compuerta, bus_a.senal_alarma_pin);
    end
  endtask

  task automatic test_reset_mid_op();
    n_cmp++;
    if (bus_a.ocupacion !== 4'd3 || bus_a.senal_compuerta !== 1'b1) begin
      n_err++;
      $display("FAIL midop_precond: got ocup=%0d gate=%b want 3 1", bus_a.ocupacion,
               bus_a.senal_compuerta);
    end
    reset = 1'b1; tick(); reset = 1'b0; llegada = 1'b0;
    n_cmp++;
    if ({bus_a.senal_compuerta, bus_a.senal_alarma_pin, bus_a.senal_alarma_bloqueo,
         bus_a.senal_lleno} !== 4'b0000 || bus_a.ocupacion !== 4'd0) begin
      n_err++;
      $display("FAIL midop_reset: got flags=%b%b%b%b ocup=%0d want 0000 0",
               bus_a.senal_compuerta, bus_a.senal_alarma_pin, bus_a.senal_alarma_bloqueo,
               bus_a.senal_lleno, bus_a.ocupacion);
    end
  endtask

  task automatic test_full_lot();
    full_entry();
    full_entry();
    n_cmp++;
    if (bus_b.ocupacion !== 2'd2 || bus_b.senal_lleno !== 1'b1) begin
      n_err++;
      $display("FAIL full_reached: got ocup=%0d lleno=%b want 2 1", bus_b.ocupacion,
               bus_b.senal_lleno);
    end
    llegada = 1'b1; tick();
    pin(Clave);
    n_cmp++;
    if (bus_b.senal_compuerta !== 1'b0) begin
      n_err++; $display("FAIL full_no_gate: got gate=%b want 0", bus_b.senal_compuerta);
    end
    llegada = 1'b0; tick();
    salida = 1'b1; tick(); salida = 1'b0; tick();
    n_cmp++;
    if (bus_b.ocupacion !== 2'd1 || bus_b.senal_lleno !== 1'b0) begin
      n_err++;
      $display("FAIL full_departure: got ocup=%0d lleno=%b want 1 0", bus_b.ocupacion,
               bus_b.senal_lleno);
    end
    full_entry();
    salida = 1'b1;
    repeat (5) tick();
    salida = 1'b0; tick();
    n_cmp++;
    if (bus_b.ocupacion !== 2'd1) begin
      n_err++; $display("FAIL held_salida: got ocup=%0d want 1", bus_b.ocupacion);
    end
    llegada = 1'b1; tick();
    pin(Clave);
    ingreso = 1'b1; llegada = 1'b0; salida = 1'b1; tick();
    ingreso = 1'b0; salida = 1'b0; tick();
    n_cmp++;
    if (bus_b.ocupacion !== 2'd1 || bus_b.senal_lleno !== 1'b0) begin
      n_err++;
      $display("FAIL simultaneous: got ocup=%0d lleno=%b want 1 0", bus_b.ocupacion,
               bus_b.senal_lleno);
    end
  endtask

  task automatic test_random();
    logic [3:0] ea;
    logic [1:0] eb;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      llegada = ($urandom_range(0, 99) < 60);
      ingreso = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 15) salida = ~salida;
      valida  = ($urandom_range(0, 99) < 20);
      clave   = $urandom_range(0, 1) ? Clave : 16'($urandom);
      tick();
      ea = 4'(m_occ[0]);
      eb = 2'(m_occ[1]);
      n_cmp++;
      if (bus_a.senal_compuerta !== (m_mode[0] == ModeGateUp) ||
          bus_a.senal_alarma_pin !== m_apin[0] || bus_a.senal_alarma_bloqueo !== m_abloq[0] ||
          bus_a.ocupacion !== ea || bus_a.senal_lleno !== (m_occ[0] == cap[0])) begin
        n_err++;
        $display("FAIL rand_a cyc %0d: got g%b p%b b%b o%0d l%b want g%b p%b b%b o%0d l%b", c,
                 bus_a.senal_compuerta, bus_a.senal_alarma_pin, bus_a.senal_alarma_bloqueo,
                 bus_a.ocupacion, bus_a.senal_lleno, m_mode[0] == ModeGateUp, m_apin[0],
                 m_abloq[0], ea, m_occ[0] == cap[0]);
      end
      n_cmp++;
      if (bus_b.senal_compuerta !== (m_mode[1] == ModeGateUp) ||
          bus_b.senal_alarma_pin !== m_apin[1] || bus_b.senal_alarma_bloqueo !== m_abloq[1] ||
          bus_b.ocupacion !== eb || bus_b.senal_lleno !== (m_occ[1] == cap[1])) begin
        n_err++;
        $display("FAIL rand_b cyc %0d: got g%b p%b b%b o%0d l%b want g%b p%b b%b o%0d l%b", c,
                 bus_b.senal_compuerta, bus_b.senal_alarma_pin, bus_b.senal_alarma_bloqueo,
                 bus_b.ocupacion, bus_b.senal_lleno, m_mode[1] == ModeGateUp, m_apin[1],
                 m_abloq[1], eb, m_occ[1] == cap[1]);
      end
    end
    reset = 1'b0; valida = 1'b0; ingreso = 1'b0; llegada = 1'b0; salida = 1'b0;
  endtask

  initial begin
    cap[0] = 8;
    cap[1] = 2;
    test_reset();
    test_normal_entry();
    test_wrong_pin();
    test_tailgate();
    test_timeout();
    test_reset_mid_op();
    test_full_lot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
